// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath blocks.
// Holds the digit width, the serial adder state encoding and the index-width helper.
package calc_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } adder_state_t;

   // A one-digit adder still needs a 1-bit index register.
   function automatic int idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/nibble_adder_4.sv
// Combinational 4-bit ripple-carry adder built from per-bit full adders.
// Shared by every digit step of the serial adder.
module nibble_adder_4 (
   input  logic [3:0] A_in4,
   input  logic [3:0] B_in4,
   input  logic       Carry_in,
   output logic [3:0] Sum_out4,
   output logic       Carry_out
);

   logic [4:0] w_carry;

   assign w_carry[0] = Carry_in;

   for (genvar g = 0; g < 4; g++) begin : g_fa
      assign Sum_out4[g]    = A_in4[g] ^ B_in4[g] ^ w_carry[g];
      assign w_carry[g + 1] = (A_in4[g] & B_in4[g]) | (w_carry[g] & (A_in4[g] ^ B_in4[g]));
   end

   assign Carry_out = w_carry[4];

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-digit adder that processes one nibble per clock, LSB first, through one 4-bit cell.
// Signed overflow tracking is compiled in only when SERIAL_ADDER_OVERFLOW_EN is defined.
//
// state | meaning
// IDLE  | ready for a start request
// ADD   | one nibble summed per cycle, index 0..NIBBLES-1
// DONE  | result registers freshly loaded, one-cycle pulse
module serial_nibble_adder
   import calc_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                      Clock_in,
   input  logic                      Reset_in,
   input  logic                      Start_in,
   input  logic [NIBBLE_W*NIBBLES-1:0] A_in,
   input  logic [NIBBLE_W*NIBBLES-1:0] B_in,
   input  logic                      Carry_in,
   output logic                      Ready_out,
   output logic                      Busy_out,
   output logic                      Done_out,
   output logic [NIBBLE_W*NIBBLES-1:0] Sum_out,
   output logic                      Carry_out,
   output logic                      Overflow_out
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   adder_state_t r_state;
   adder_state_t w_state_next;

   logic [W-1:0]        r_a;
   logic [W-1:0]        r_b;
   logic [W-1:0]        r_res;
   logic                r_carry;
   logic [IDX_W-1:0]    r_idx;
   logic [W-1:0]        r_sum;
   logic                r_cout;

   logic [NIBBLE_W-1:0] w_sum4;
   logic                w_cout4;
   logic [W-1:0]        w_res_next;
   logic                w_last;

   nibble_adder_4 u_cell (
      .A_in4     (r_a[NIBBLE_W-1:0]),
      .B_in4     (r_b[NIBBLE_W-1:0]),
      .Carry_in  (r_carry),
      .Sum_out4  (w_sum4),
      .Carry_out (w_cout4)
   );

   // New digit enters at the top; after NIBBLES shifts the result is aligned.
   assign w_res_next = (r_res >> NIBBLE_W) | (W'(w_sum4) << (W - NIBBLE_W));
   assign w_last     = (r_idx == LAST_IDX);

   always_ff @(posedge Clock_in) begin
      if (Reset_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (Start_in) w_state_next = ADD;
         ADD:     if (w_last)   w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock_in) begin
      if (Reset_in) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (Start_in) begin
                  r_a     <= A_in;
                  r_b     <= B_in;
                  r_carry <= Carry_in;
                  r_res   <= '0;
                  r_idx   <= '0;
               end
            end
            ADD: begin
               r_a     <= r_a >> NIBBLE_W;
               r_b     <= r_b >> NIBBLE_W;
               r_carry <= w_cout4;
               r_res   <= w_res_next;
               r_idx   <= r_idx + IDX_W'(1);
               if (w_last) begin
                  r_sum  <= w_res_next;
                  r_cout <= w_cout4;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_ADDER_OVERFLOW_EN
   // Operand sign bits are shifted out of r_a/r_b, so they are kept separately.
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;

   always_ff @(posedge Clock_in) begin
      if (Reset_in) begin
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (r_state == IDLE && Start_in) begin
            r_a_msb <= A_in[W-1];
            r_b_msb <= B_in[W-1];
         end
         if (r_state == ADD && w_last) begin
            r_ovf <= (r_a_msb == r_b_msb) && (w_sum4[NIBBLE_W-1] != r_a_msb);
         end
      end
   end

   assign Overflow_out = r_ovf;
`else
   assign Overflow_out = 1'b0;
`endif

   assign Ready_out = (r_state == IDLE);
   assign Busy_out  = (r_state == ADD);
   assign Done_out  = (r_state == DONE);
   assign Sum_out   = r_sum;
   assign Carry_out = r_cout;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed bench for serial_nibble_adder (NIBBLES=4) with a result scoreboard.
module tb_serial_nibble_adder;

   localparam int N = 4;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         c_in;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           start_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   logic [W-1:0] last_sum = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_nibble_adder #(.NIBBLES(N)) dut (
      .Clock_in     (clk),
      .Reset_in     (rst),
      .Start_in     (start),
      .A_in         (a_in),
      .B_in         (b_in),
      .Carry_in     (c_in),
      .Ready_out    (ready),
      .Busy_out     (busy),
      .Done_out     (done),
      .Sum_out      (sum),
      .Carry_out    (cout),
      .Overflow_out (ovf)
   );

   function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] s);
`ifdef SERIAL_ADDER_OVERFLOW_EN
      return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every Done pulse must match the oldest pending request.
   always @(negedge clk) begin
      if (done) begin
         exp_t e;
         done_cnt++;
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_done observed=1 expected=0 cyc=%0d", cyc);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sum", 32'(sum), 32'(e.sum));
            chk("carry_out", 32'(cout), 32'(e.cout));
            chk("overflow", 32'(ovf), 32'(e.ovf));
            chk("latency", 32'(cyc - e.start_cyc), 32'(N));
            last_sum = e.sum;
         end
      end
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input bit push);
      logic [W:0] full;
      exp_t e;
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      c_in  = c;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      c_in  = 1'($urandom);
      if (push) begin
         full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
         e.sum = full[W-1:0];
         e.cout = full[W];
         e.ovf = model_ovf(a, b, full[W-1:0]);
         e.start_cyc = cyc;
         sb.push_back(e);
      end
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("ready_after_start", 32'(ready), 32'd0);
   endtask

   task automatic wait_done(input int d0, input int target);
      for (int i = 0; i < 40 && done_cnt < d0 + target; i++) begin
         @(negedge clk);
         #1;
      end
      checks++;
      assert (done_cnt >= d0 + target) else begin
         errors++;
         $error("FAIL done_timeout observed=%0d expected=%0d", done_cnt - d0, target);
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int d0;
      d0 = done_cnt;
      start_op(a, b, c, 1'b1);
      wait_done(d0, 1);
   endtask

   initial begin
      int d0;
      int s0;
      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      c_in  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;

      run_op(16'h1234, 16'h4321, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b1);
      run_op(16'h7FFF, 16'h0001, 1'b0);
      run_op(16'h8000, 16'h8000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom));
      end

      // Start pulse during ADD must be ignored.
      @(negedge clk);
      chk("sum_held", 32'(sum), 32'(last_sum));
      d0 = done_cnt;
      start_op(16'h1111, 16'h1111, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      a_in  = 16'h2222;
      b_in  = 16'h2222;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("sum_held_mid_op", 32'(sum), 32'(last_sum));
      wait_done(d0, 1);
      repeat (10) @(negedge clk);
      #1;
      chk("single_done", 32'(done_cnt - d0), 32'd1);

      // Reset during ADD aborts silently.
      run_op(16'h1234, 16'h4321, 1'b0);
      d0 = done_cnt;
      start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

      // Start held high: new addition every N+2 cycles.
      d0 = done_cnt;
      @(negedge clk);
      a_in  = 16'h0F0F;
      b_in  = 16'h00F1;
      c_in  = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      s0 = cyc;
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         e.sum = 16'h1000;
         e.cout = 1'b0;
         e.ovf = 1'b0;
         e.start_cyc = s0 + k * (N + 2);
         sb.push_back(e);
      end
      repeat (2 * (N + 2)) @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(d0, 3);
      repeat (10) @(negedge clk);
      #1;
      chk("held_done_count", 32'(done_cnt - d0), 32'd3);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_nibble_adder.md
# serial_nibble_adder

Sequential multi-digit adder for the calculator datapath: adds two `4*NIBBLES`-bit operands one nibble per clock, least-significant nibble first, through a single 4-bit ripple adder cell. It is the addition counterpart to the team's 4-bit ripple subtractor and sits beside it in the calculation unit. The calculator controller drives it through a start/ready/done handshake.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit digits per operand. Operand width W = 4*NIBBLES. Legal range is 1..8.

Ports:
- `Clock_in` in 1: single clock, rising edge.
- `Reset_in` in 1: synchronous, active-high reset.
- `Start_in` in 1: request an addition. Sampled only when `Ready_out`=1.
- `A_in` in W: operand A, captured on the start edge.
- `B_in` in W: operand B, captured on the start edge.
- `Carry_in` in 1: initial carry into nibble 0, captured on the start edge.
- `Ready_out` out 1: block is idle and will accept `Start_in`.
- `Busy_out` out 1: an addition is in progress.
- `Done_out` out 1: one-cycle pulse; `Sum_out` and `Carry_out` are valid and new.
- `Sum_out` out W: result of the last completed addition, held until the next completion.
- `Carry_out` out 1: carry out of the MSB nibble of the last completed addition.
- `Overflow_out` out 1: two's-complement overflow of the last completed addition (see Configuration).

## Operation
- States:
  - IDLE: `Ready_out`=1.
  - ADD: `Busy_out`=1. Nibble index runs from 0 to NIBBLES-1.
  - DONE: `Done_out`=1.
- IDLE with `Start_in`=1 → ADD:
  - Latch `A_in`, `B_in` and `Carry_in` into internal shift registers.
  - Set the nibble index to 0.
- Each ADD cycle:
  - The 4-bit adder cell adds the low nibbles of the A and B shift registers plus the running carry.
  - The sum nibble shifts into the top of the internal result register. Both operand registers shift right by 4.
  - The running carry is updated and the index increments.
- ADD with index = NIBBLES-1 → DONE:
  - Load the internal result into `Sum_out`.
  - Load the final carry into `Carry_out`.
  - Load the overflow term into `Overflow_out`.
- DONE → IDLE unconditionally after one cycle.
- `Start_in` in ADD or DONE is ignored, not queued. `A_in` and `B_in` may change freely after the start edge.
- Arithmetic: unsigned sum modulo 2^W, with carry-out in `Carry_out`. Overflow = (A[W-1] == B[W-1]) && (Sum[W-1] != A[W-1]).
- Reset, including mid-operation:
  - State → IDLE.
  - `Sum_out`=0, `Carry_out`=0, `Overflow_out`=0, `Done_out`=0, `Busy_out`=0, `Ready_out`=1.
  - Internal registers are cleared.
  - An aborted addition produces no `Done_out`.

## Timing
- Start accepted at edge E0, where `Start_in`=1 and `Ready_out`=1.
- Nibble k is computed in the cycle after edge Ek and registered at edge Ek+1, for k = 0..NIBBLES-1.
- Result registered at edge E_NIBBLES. `Done_out`=1 for exactly the cycle following that edge.
- `Ready_out` returns high after edge E_NIBBLES+1.
- Latency from start edge to `Done_out` rising is NIBBLES cycles. Throughput is one addition per NIBBLES+2 cycles.
- `Start_in` held high continuously starts a new addition at each IDLE cycle. Back-to-back period is NIBBLES+2 cycles.
- `Sum_out` changes only at the DONE-entry edge or at reset. Combinational inputs never reach outputs.

## Configuration
- Macro `SERIAL_ADDER_OVERFLOW_EN`:
  - Defined: the MSB sign-tracking logic is compiled in, and `Overflow_out` reports signed overflow as above.
  - Undefined: the logic is removed and `Overflow_out` is tied to 0. The port list is unchanged in both builds.

## Structure
- Shared package `calc_pkg`:
  - Constant `NIBBLE_W` = 4.
  - State typedef `adder_state_t` (IDLE, ADD, DONE), 2-bit encoding.
  - Index width function or constant, sized by `$clog2(NIBBLES)`.
- One sub-module: `nibble_adder_4`. It is a combinational 4-bit ripple adder with ports `A_in4`, `B_in4`, `Carry_in`, `Sum_out4`, `Carry_out`, built from per-bit full adders. It is instantiated once and reused every ADD cycle.
- Top level holds the FSM, index counter, operand/result shift registers and output registers.

## Test plan
All cases use NIBBLES=4.
- 0x1234 + 0x4321, Carry_in=0, start at E0 → `Done_out` one cycle after E4; `Sum_out`=0x5555, `Carry_out`=0, `Overflow_out`=0.
- 0xFFFF + 0x0001, Carry_in=0 → `Sum_out`=0x0000, `Carry_out`=1, `Overflow_out`=0. 0x0000 + 0x0000, Carry_in=1 → `Sum_out`=0x0001, `Carry_out`=0.
- 0x7FFF + 0x0001 → `Sum_out`=0x8000, `Carry_out`=0. `Overflow_out`=1 with `SERIAL_ADDER_OVERFLOW_EN` defined, 0 without.
- Start 0x1111+0x1111, then pulse `Start_in` with 0x2222+0x2222 at E2 → second request ignored; `Sum_out`=0x2222; exactly one `Done_out`.
- Complete 0x1234+0x4321, then start 0xAAAA+0x5555 and assert `Reset_in` at E2 → from the next edge `Ready_out`=1, `Sum_out`=0, `Carry_out`=0, and no `Done_out` for the aborted operation.
- `Start_in` held high with constant operands 0x0F0F+0x00F1 → `Done_out` pulses every 6 cycles, each time with `Sum_out`=0x1000.
